// File: rtl/multi_press_pkg.sv
// multi_press_pkg: shared state encoding, default timing constants and width helper
// for the multi-press decoder and its millisecond tick generator.
package multi_press_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam int DEF_CLK_DIV     = 100000;
   localparam int DEF_WINDOW_MS   = 300;
   localparam int DEF_MAX_PRESSES = 7;
   localparam int DEF_CNT_W       = 3;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running CLK_DIV prescaler emitting a one-cycle tick on its last count.
module ms_tick_gen
   import multi_press_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int PW = width_for(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;

   assign tick_o  = (presc_q == PRESC_LAST);
   assign presc_d = tick_o ? '0 : presc_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) presc_q <= '0;
      else       presc_q <= presc_d;
   end

endmodule

// File: rtl/multi_press_decoder.sv
// multi_press_decoder: groups debounced presses into bursts ended by a quiet window and
// reports the burst size. Define MULTI_PRESS_HANDSHAKE_EN to hold reports until pressAck1.
module multi_press_decoder
   import multi_press_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int WINDOW_MS   = DEF_WINDOW_MS,
   parameter int MAX_PRESSES = DEF_MAX_PRESSES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clock1,
   input  logic             reset1,
   input  logic             btnPressed1,
   input  logic             pressAck1,
   output logic [CNT_W-1:0] pressCount1,
   output logic             pressValid1,
   output logic             busy1,
   output logic             overrun1
);

   localparam int WW = width_for(WINDOW_MS);
   localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW_MS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PRESSES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q;
   logic [WW-1:0]    win_q;
   logic [CNT_W-1:0] cnt_q, rep_q, cnt_inc;
   logic             valid_q, tick;

   ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i (clock1),
      .rst_i (reset1),
      .tick_o(tick)
   );

   assign cnt_inc     = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
   assign pressCount1 = rep_q;
   assign pressValid1 = valid_q;
   assign busy1       = (state_q != IDLE);

`ifdef MULTI_PRESS_HANDSHAKE_EN
   logic ovr_q;
   assign overrun1 = ovr_q;

   always_ff @(posedge clock1 or posedge reset1) begin
      if (reset1) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         rep_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         case (state_q)
            IDLE: if (btnPressed1) begin
               state_q <= COLLECT;
               cnt_q   <= CNT_ONE;
               win_q   <= '0;
            end
            COLLECT: if (btnPressed1) begin
               cnt_q <= cnt_inc;
               win_q <= '0;
            end else if (tick) begin
               if (win_q == WIN_LAST) begin
                  state_q <= REPORT;
                  rep_q   <= cnt_q;
                  valid_q <= 1'b1;
               end else win_q <= win_q + 1'b1;
            end
            // An ack frees the slot, so a coincident press opens a new burst.
            REPORT: if (pressAck1) begin
               valid_q <= 1'b0;
               state_q <= btnPressed1 ? COLLECT : IDLE;
               cnt_q   <= CNT_ONE;
               win_q   <= '0;
            end else if (btnPressed1) ovr_q <= 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end
`else
   logic unused_ack;
   assign unused_ack = pressAck1;
   assign overrun1   = 1'b0;

   always_ff @(posedge clock1 or posedge reset1) begin
      if (reset1) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         rep_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (btnPressed1) begin
               state_q <= COLLECT;
               cnt_q   <= CNT_ONE;
               win_q   <= '0;
            end
            COLLECT: if (btnPressed1) begin
               cnt_q <= cnt_inc;
               win_q <= '0;
            end else if (tick) begin
               if (win_q == WIN_LAST) begin
                  state_q <= REPORT;
                  rep_q   <= cnt_q;
                  valid_q <= 1'b1;
               end else win_q <= win_q + 1'b1;
            end
            // Single-cycle report; a press landing here starts the next burst.
            REPORT: begin
               valid_q <= 1'b0;
               state_q <= btnPressed1 ? COLLECT : IDLE;
               cnt_q   <= CNT_ONE;
               win_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_multi_press_decoder.sv
// tb_multi_press_decoder: table-driven bursts plus hand-written corner sequences, checked
// by a scoreboard of expected {count, report cycle}; follows MULTI_PRESS_HANDSHAKE_EN.
module tb_multi_press_decoder;

   localparam int CLK_DIV   = 10;
   localparam int WINDOW_MS = 5;
   localparam int MAXP      = 7;
   localparam int CNT_W     = 3;

   typedef struct {
      int cnt;
      int cyc;
   } exp_t;

   typedef struct {
      int n;
      int gap;
      int cnt;
   } vec_t;

   logic             clk, rst, btn, ack;
   logic [CNT_W-1:0] cnt_o;
   logic             valid_o, busy_o, ovr_o;

   int   tests = 0, fails = 0;
   int   cyc, ovr_seen = 0, exp_ovr = 0;
   logic vprev, rise_q;
   exp_t sb[$];
   vec_t vecs[6];

   multi_press_decoder #(
      .CLK_DIV(CLK_DIV), .WINDOW_MS(WINDOW_MS), .MAX_PRESSES(MAXP), .CNT_W(CNT_W)
   ) dut (
      .clock1(clk), .reset1(rst), .btnPressed1(btn), .pressAck1(ack),
      .pressCount1(cnt_o), .pressValid1(valid_o), .busy1(busy_o), .overrun1(ovr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index since reset release; it equals the number of prescaler steps taken.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycle in which pressValid1 first reads high for a burst whose last press is in cycle c.
   function automatic int exp_cycle(input int c);
      int t = c + 1;
      while (t % CLK_DIV != CLK_DIV - 1) t++;
      return t + (WINDOW_MS - 1) * CLK_DIV + 1;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         vprev  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         if (valid_o && !vprev) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_report: got count %0d at cycle %0d, required no report", cnt_o, cyc);
            end else begin
               chk("report_count", int'(cnt_o), sb[0].cnt);
               chk("report_cycle", cyc, sb[0].cyc);
               sb.delete(0);
            end
         end
`ifndef MULTI_PRESS_HANDSHAKE_EN
         if (rise_q) chk("pulse_width", int'(valid_o), 0);
`endif
         if (ovr_o) ovr_seen <= ovr_seen + 1;
         vprev  <= valid_o;
         rise_q <= valid_o && !vprev;
      end
   end

   task automatic do_press(output int c);
      c   = cyc;
      btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
   endtask

   task automatic wait_until(input int x);
      int k = 0;
      while (cyc < x && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("align_cycle", cyc, x);
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || busy_o) && k < 2000) begin
`ifdef MULTI_PRESS_HANDSHAKE_EN
         ack = valid_o && !ack;
`endif
         @(negedge clk);
         k++;
      end
      ack = 1'b0;
      chk("drain_done", int'(k < 2000), 1);
      chk("idle_busy", int'(busy_o), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_count"}, int'(cnt_o), 0);
      chk({tag, "_valid"}, int'(valid_o), 0);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_overrun"}, int'(ovr_o), 0);
   endtask

   task automatic push(input int cnt, input int c);
      exp_t e;
      e.cnt = cnt;
      e.cyc = exp_cycle(c);
      sb.push_back(e);
   endtask

   initial begin
      int c, r;
      vecs[0] = '{n: 1,  gap: 1,  cnt: 1};
      vecs[1] = '{n: 3,  gap: 15, cnt: 3};
      vecs[2] = '{n: 10, gap: 5,  cnt: 7};
      vecs[3] = '{n: 7,  gap: 3,  cnt: 7};
      vecs[4] = '{n: 8,  gap: 12, cnt: 7};
      vecs[5] = '{n: 2,  gap: 39, cnt: 2};
      rst = 1'b1;
      btn = 1'b0;
      ack = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      wait_until(20);
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vecs[i].n; j++) begin
            do_press(c);
            if (j < vecs[i].n - 1) repeat (vecs[i].gap - 1) @(negedge clk);
         end
         push(vecs[i].cnt, c);
         drain();
      end
      // press on the expiry tick extends the burst by a full window
      do_press(c);
      wait_until(exp_cycle(c) - 1);
      do_press(c);
      push(2, c);
      drain();
      // ack while collecting has no effect
      do_press(c);
      push(1, c);
      ack = 1'b1;
      repeat (20) @(negedge clk);
      ack = 1'b0;
      drain();
`ifdef MULTI_PRESS_HANDSHAKE_EN
      do_press(c);
      repeat (14) @(negedge clk);
      do_press(c);
      r = exp_cycle(c);
      push(2, c);
      wait_until(r);
      do_press(c);
      exp_ovr++;
      chk("ovr_pulse", int'(ovr_o), 1);
      chk("ovr_valid_held", int'(valid_o), 1);
      chk("ovr_count_held", int'(cnt_o), 2);
      @(negedge clk);
      chk("ovr_one_cycle", int'(ovr_o), 0);
      chk("valid_still_held", int'(valid_o), 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack_valid_drop", int'(valid_o), 0);
      chk("ack_idle", int'(busy_o), 0);
      do_press(c);
      repeat (14) @(negedge clk);
      do_press(c);
      r = exp_cycle(c);
      push(2, c);
      wait_until(r);
      ack = 1'b1;
      do_press(c);
      ack = 1'b0;
      push(1, c);
      chk("ackpress_valid", int'(valid_o), 0);
      chk("ackpress_busy", int'(busy_o), 1);
      chk("ackpress_overrun", int'(ovr_o), 0);
      drain();
`else
      do_press(c);
      r = exp_cycle(c);
      push(1, c);
      wait_until(r);
      do_press(c);
      push(1, c);
      drain();
`endif
      // reset mid-COLLECT
      do_press(c);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("rst_collect");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      do_press(c);
      push(1, c);
      drain();
      // reset mid-REPORT
      do_press(c);
      repeat (9) @(negedge clk);
      do_press(c);
      r = exp_cycle(c);
      push(2, c);
      wait_until(r);
      #2 chk("pre_reset_valid", int'(valid_o), 1);
      rst = 1'b1;
      #1 chk_zero("rst_report");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      do_press(c);
      push(1, c);
      drain();
      repeat (2) @(negedge clk);
      #1 chk("overrun_pulses", ovr_seen, exp_ovr);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_press_decoder.md
# multi_press_decoder

Consumes the one-cycle debounced press pulse (btnPressed1) from the button debouncer and groups consecutive presses into bursts separated by a quiet window. At the end of each burst it reports the press count (single, double, triple, …) to the mode/control logic. It sits between the debouncer and any user-mode FSM on the board's 100 MHz domain.

## Interface
- CLK_DIV, 100000: clock cycles per 1 ms tick (100 MHz → 1 kHz).
- WINDOW_MS, 300: quiet window in ticks; a burst ends when no press arrives within it.
- MAX_PRESSES, 7: saturation value of the press count; must be ≤ 2^CNT_W − 1.
- CNT_W, 3: width of the press count.
- clock1  in  1  system clock, 100 MHz, all logic on its rising edge.
- reset1  in  1  asynchronous, active-high reset.
- btnPressed1  in  1  debounced press pulse, one cycle wide per press.
- pressAck1  in  1  consumer acknowledge; used only with MULTI_PRESS_HANDSHAKE_EN.
- pressCount1  out  CNT_W  press count of the last reported burst.
- pressValid1  out  1  report strobe/valid for pressCount1.
- busy1  out  1  high while a burst is being collected or a report is pending.
- overrun1  out  1  one-cycle pulse per press dropped while a report is pending.

## Operation
- Reset values: pressCount1=0, pressValid1=0, busy1=0, overrun1=0, state IDLE, prescaler=0, window=0, internal count=0.
- Prescaler is free-running from 0 to CLK_DIV−1 and wraps. Tick is one cycle high when prescaler==CLK_DIV−1.
- States:
  - IDLE: a press loads count=1, clears window to 0, and moves to COLLECT.
  - COLLECT: a press does count=min(count+1, MAX_PRESSES), clears window to 0, and stays. Otherwise, on tick, window increments. When tick arrives with window==WINDOW_MS−1, the burst expires and moves to REPORT.
  - REPORT: in pulse mode, lasts one cycle and returns to IDLE. In handshake mode, holds until pressAck1.
- Press and expiry in the same cycle: the press wins. Count increments, window clears, and no report is made.
- Presses beyond MAX_PRESSES still restart the window. The count stays saturated.
- On entry to REPORT, pressCount1 is loaded with the count. It holds until the next report.
- busy1 = (state != IDLE).
- Window is measured from a press to expiry in ticks, so the quiet time is between WINDOW_MS−1 ms and WINDOW_MS ms. Tick phase is not aligned to presses.

## Timing
- pressValid1 is registered. It goes high the cycle after the expiry tick.
- Pulse mode: pressValid1 is high for exactly 1 cycle.
  - A press on the REPORT cycle is not lost: the next state is COLLECT with count=1.
  - overrun1 never asserts.
- Handshake mode: pressValid1 and pressCount1 stay stable until the cycle after pressAck1 is sampled high in REPORT.
  - A press in REPORT without ack: dropped, overrun1 pulses for 1 cycle.
  - A press and ack in the same cycle: go to COLLECT with count=1, no overrun.
  - Ack outside REPORT is ignored.
- Reset mid-burst or mid-report: all outputs return to reset values asynchronously. The partial burst is discarded.

## Configuration
- MULTI_PRESS_HANDSHAKE_EN defined: REPORT holds pressValid1 until pressAck1, and the overrun1 logic is present.
- Not defined: pressAck1 is ignored, REPORT is a single cycle, and overrun1 is tied to 0.

## Structure
- Shared package/include multi_press_pkg holds:
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, REPORT=2'd2);
  - the default CLK_DIV, WINDOW_MS and MAX_PRESSES constants;
  - the prescaler width derivation.
- One sub-module, ms_tick_gen, contains the CLK_DIV prescaler and its one-cycle tick output. It is reusable by other timed UI blocks.
- The FSM, window counter and output registers live in the top module.

## Test plan
The bench uses CLK_DIV=10 and WINDOW_MS=5.
- Single press at cycle 20, none after → pressValid1 pulses once with pressCount1=1 between 40 and 50 cycles after the press. busy1 is low afterwards.
- Three presses 15 cycles apart → one report with pressCount1=3. No intermediate report.
- Ten presses 5 cycles apart → one report with pressCount1=7 (saturated).
- Press on the exact expiry-tick cycle → no report on that expiry. The count becomes n+1 and the report follows a full window later.
- Handshake mode:
  - two presses, report with pressCount1=2;
  - a press during the pending report gives overrun1=1 for 1 cycle, with pressValid1 held;
  - ack → pressValid1 drops the next cycle and the state returns to IDLE;
  - ack coinciding with a press → state COLLECT, count=1.
- reset1 asserted mid-COLLECT and mid-REPORT → all outputs are 0 immediately. A press after release starts a fresh burst with count=1.
